hsv_color_threshold: RTL and testbench

- Downstream consumer of the RGB-to-HSV stage.
- Walks the HSV plane in SRAM and classifies each pixel against a programmable H/S/V window, with hue wrap-around support.
- Writes a binary mask plane back to SRAM and reports the match count and the bounding box of matching pixels.
- Feeds the blob/tracking stages that follow.

---
 rtl/hsv_color_threshold.sv | 237 +++++++++++++++++++++++
 tb/tb_hsv_color_threshold.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_color_threshold.sv
// HSV window classifier: walks the HSV plane, writes a binary mask plane, counts matches.
// Define HSV_THRESHOLD_BBOX_EN to build the bounding box of matching pixels.
module hsv_color_threshold #(
  parameter int ImageWidth = 320,
  parameter int ImageHeight = 240,
  parameter int HSVStorageOffset = (ImageWidth*ImageHeight)*2+2,
  parameter int MaskStorageOffset = (ImageWidth*ImageHeight)*3+3,
  parameter logic [7:0] NoHueCode = 8'hC0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pause,
  input  logic [31:0] data_read,
  output logic [17:0] address,
  output logic        wren,
  output logic [31:0] data_write,
  input  logic [7:0]  hue_min,
  input  logic [7:0]  hue_max,
  input  logic [7:0]  sat_min,
  input  logic [7:0]  sat_max,
  input  logic [7:0]  val_min,
  input  logic [7:0]  val_max,
  output logic        done,
  output logic [16:0] match_count,
  output logic        bbox_valid,
  output logic [8:0]  bbox_x_min,
  output logic [8:0]  bbox_x_max,
  output logic [7:0]  bbox_y_min,
  output logic [7:0]  bbox_y_max
);

  localparam int NPix = ImageWidth * ImageHeight;
  localparam logic [16:0] LastPix = 17'(NPix - 1);
  localparam logic [8:0]  LastX   = 9'(ImageWidth - 1);
  localparam logic [17:0] HsvOff  = 18'(HSVStorageOffset);
  localparam logic [17:0] MaskOff = 18'(MaskStorageOffset);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    EVAL,
    ADVANCE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [17:0] r_addr;
  logic        r_wren;
  logic [31:0] r_wdata;
  logic        r_done;
  logic [16:0] r_cnt;
  logic [8:0]  r_x;
  logic [7:0]  r_y;
  logic [16:0] r_mcnt;
  logic [7:0]  r_hmin;
  logic [7:0]  r_hmax;
  logic [7:0]  r_smin;
  logic [7:0]  r_smax;
  logic [7:0]  r_vmin;
  logic [7:0]  r_vmax;

  logic [7:0] w_h;
  logic [7:0] w_s;
  logic [7:0] w_v;
  logic       w_hue_ok;
  logic       w_sat_ok;
  logic       w_val_ok;
  logic       w_match;
  logic       w_last;
  logic       w_run;
  logic       w_start;
  logic       w_hit;

  assign w_h = data_read[31:24];
  assign w_s = data_read[15:8];
  assign w_v = data_read[7:0];

  // A window with min > max wraps around on hue but is empty on S/V
  always_comb begin
    w_hue_ok = 1'b0;
    if (w_h != NoHueCode) begin
      if (r_hmin <= r_hmax)
        w_hue_ok = (w_h >= r_hmin) && (w_h <= r_hmax);
      else
        w_hue_ok = (w_h >= r_hmin) || (w_h <= r_hmax);
    end
  end

  assign w_sat_ok = (w_s >= r_smin) && (w_s <= r_smax);
  assign w_val_ok = (w_v >= r_vmin) && (w_v <= r_vmax);
  assign w_match  = w_hue_ok && w_sat_ok && w_val_ok;
  assign w_last   = (r_cnt == LastPix);

  assign w_run   = enable && !pause;
  assign w_start = w_run && (r_state == IDLE) && !r_done;
  assign w_hit   = w_run && (r_state == EVAL) && w_match;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = IDLE;
    end else if (!pause) begin
      unique case (r_state)
        IDLE:    if (!r_done) w_next = ADDR;
        ADDR:    w_next = EVAL;
        EVAL:    w_next = ADVANCE;
        ADVANCE: w_next = w_last ? IDLE : ADDR;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wren  <= 1'b0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_mcnt  <= '0;
      r_hmin  <= '0;
      r_hmax  <= '0;
      r_smin  <= '0;
      r_smax  <= '0;
      r_vmin  <= '0;
      r_vmax  <= '0;
    end else if (!enable) begin
      r_addr  <= '0;
      r_wren  <= 1'b0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (!pause) begin
      unique case (r_state)
        IDLE: begin
          if (!r_done) begin
            r_hmin <= hue_min;
            r_hmax <= hue_max;
            r_smin <= sat_min;
            r_smax <= sat_max;
            r_vmin <= val_min;
            r_vmax <= val_max;
            r_mcnt <= '0;
          end
        end
        ADDR: begin
          r_wren <= 1'b0;
          r_addr <= {1'b0, r_cnt} + HsvOff;
        end
        EVAL: begin
          r_addr  <= {1'b0, r_cnt} + MaskOff;
          r_wdata <= {32{w_match}};
          r_wren  <= 1'b1;
          if (w_match) r_mcnt <= r_mcnt + 17'd1;
        end
        ADVANCE: begin
          r_wren <= 1'b0;
          r_cnt  <= r_cnt + 17'd1;
          if (r_x == LastX) begin
            r_x <= '0;
            r_y <= r_y + 8'd1;
          end else begin
            r_x <= r_x + 9'd1;
          end
          if (w_last) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign address     = r_addr;
  assign wren        = r_wren;
  assign data_write  = r_wdata;
  assign done        = r_done;
  assign match_count = r_mcnt;

`ifdef HSV_THRESHOLD_BBOX_EN
  logic [8:0] r_xmin;
  logic [8:0] r_xmax;
  logic [7:0] r_ymin;
  logic [7:0] r_ymax;
  logic       w_unused;

  // Zero matches so far means this hit seeds the box
  always_ff @(posedge clk) begin
    if (!reset_n || w_start) begin
      r_xmin <= '0;
      r_xmax <= '0;
      r_ymin <= '0;
      r_ymax <= '0;
    end else if (w_hit) begin
      if (r_mcnt == '0) begin
        r_xmin <= r_x;
        r_xmax <= r_x;
        r_ymin <= r_y;
        r_ymax <= r_y;
      end else begin
        if (r_x < r_xmin) r_xmin <= r_x;
        if (r_x > r_xmax) r_xmax <= r_x;
        if (r_y < r_ymin) r_ymin <= r_y;
        if (r_y > r_ymax) r_ymax <= r_y;
      end
    end
  end

  assign bbox_valid = (r_mcnt != '0);
  assign bbox_x_min = r_xmin;
  assign bbox_x_max = r_xmax;
  assign bbox_y_min = r_ymin;
  assign bbox_y_max = r_ymax;
  assign w_unused   = ^{data_read[23:16], w_hit};
`else
  logic w_unused;

  assign bbox_valid = 1'b0;
  assign bbox_x_min = '0;
  assign bbox_x_max = '0;
  assign bbox_y_min = '0;
  assign bbox_y_max = '0;
  assign w_unused   = ^{data_read[23:16], r_x, r_y, w_start, w_hit};
`endif

endmodule

// File: tb/tb_hsv_color_threshold.sv
// Randomised bench for hsv_color_threshold on a reduced 40x12 frame.
// Reference model classifies whole planes directly from the window rules.
module tb_hsv_color_threshold;

  localparam int W        = 40;
  localparam int H        = 12;
  localparam int NPIX     = W * H;
  localparam int HSV_OFF  = NPIX * 2 + 2;
  localparam int MASK_OFF = NPIX * 3 + 3;
  localparam int FRAME    = 3 * NPIX + 1;
  localparam int LIMIT    = 3 * NPIX + 200;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        pause;
  logic [31:0] data_read;
  logic [17:0] address;
  logic        wren;
  logic [31:0] data_write;
  logic [7:0]  hue_min, hue_max, sat_min, sat_max, val_min, val_max;
  logic        done;
  logic [16:0] match_count;
  logic        bbox_valid;
  logic [8:0]  bbox_x_min, bbox_x_max;
  logic [7:0]  bbox_y_min, bbox_y_max;

  logic [31:0] hsv_mem [NPIX];
  logic [31:0] mask_mem [NPIX];
  int nwr;
  int oob_wr;
  int checks;
  int errors;
  int m_h0, m_h1, m_s0, m_s1, m_v0, m_v1;
  logic [51:0] act;

  hsv_color_threshold #(
    .ImageWidth(W),
    .ImageHeight(H)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .pause(pause),
    .data_read(data_read),
    .address(address),
    .wren(wren),
    .data_write(data_write),
    .hue_min(hue_min),
    .hue_max(hue_max),
    .sat_min(sat_min),
    .sat_max(sat_max),
    .val_min(val_min),
    .val_max(val_max),
    .done(done),
    .match_count(match_count),
    .bbox_valid(bbox_valid),
    .bbox_x_min(bbox_x_min),
    .bbox_x_max(bbox_x_max),
    .bbox_y_min(bbox_y_min),
    .bbox_y_max(bbox_y_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {match_count, bbox_valid, bbox_x_min, bbox_x_max,
                bbox_y_min, bbox_y_max};

  always_comb begin
    data_read = 32'hDEADBEEF;
    if (int'(address) >= HSV_OFF && int'(address) < HSV_OFF + NPIX)
      data_read = hsv_mem[int'(address) - HSV_OFF];
  end

  always @(negedge clk) begin
    int i;
    if (wren) begin
      i = int'(address) - MASK_OFF;
      if (i >= 0 && i < NPIX) mask_mem[i] = data_write;
      else oob_wr++;
      nwr++;
    end
  end

  function automatic bit pmatch(logic [31:0] w);
    int h, s, v;
    bit hok;
    h = int'(w[31:24]);
    s = int'(w[15:8]);
    v = int'(w[7:0]);
    if (h == 192) hok = 0;
    else if (m_h0 <= m_h1) hok = (h >= m_h0) && (h <= m_h1);
    else hok = (h >= m_h0) || (h <= m_h1);
    return hok && s >= m_s0 && s <= m_s1 && v >= m_v0 && v <= m_v1;
  endfunction

  function automatic logic [51:0] exp_stats(int upto);
    int c, x0, x1, y0, y1;
    c = 0; x0 = 0; x1 = 0; y0 = 0; y1 = 0;
    for (int i = 0; i < upto; i++) begin
      if (pmatch(hsv_mem[i])) begin
        if (c == 0) begin
          x0 = i % W; x1 = i % W; y0 = i / W; y1 = i / W;
        end else begin
          if (i % W < x0) x0 = i % W;
          if (i % W > x1) x1 = i % W;
          if (i / W < y0) y0 = i / W;
          if (i / W > y1) y1 = i / W;
        end
        c++;
      end
    end
`ifdef HSV_THRESHOLD_BBOX_EN
    return {17'(c), c != 0, 9'(x0), 9'(x1), 8'(y0), 8'(y1)};
`else
    return {17'(c), 35'd0};
`endif
  endfunction

  function automatic int mask_errs();
    int n;
    n = 0;
    for (int i = 0; i < NPIX; i++)
      if (mask_mem[i] !== (pmatch(hsv_mem[i]) ? 32'hFFFFFFFF : 32'h0)) n++;
    return n;
  endfunction

  task automatic set_thr(int h0, int h1, int s0, int s1, int v0, int v1);
    m_h0 = h0; m_h1 = h1; m_s0 = s0; m_s1 = s1; m_v0 = v0; m_v1 = v1;
    hue_min = 8'(h0); hue_max = 8'(h1);
    sat_min = 8'(s0); sat_max = 8'(s1);
    val_min = 8'(v0); val_max = 8'(v1);
  endtask

  task automatic clear_planes();
    for (int i = 0; i < NPIX; i++) hsv_mem[i] = 32'h0;
  endtask

  task automatic rand_plane(int dense);
    for (int i = 0; i < NPIX; i++) begin
      hsv_mem[i] = $urandom;
      if ($urandom_range(0, 15) == 0) hsv_mem[i][31:24] = 8'hC0;
      if (dense != 0 && $urandom_range(0, 1) == 0)
        hsv_mem[i][15:0] = 16'h8080;
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < NPIX; i++) mask_mem[i] = 32'h5A5A5A5A;
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic wait_done(output int n, output bit to);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < LIMIT);
    to = !done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    pause = 1'b0;
    set_thr(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (address !== 18'h0) begin
      errors++; $display("FAIL reset_addr: got %0h want 0", address);
    end
    checks++;
    if ({wren, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b want 00", {wren, done});
    end
    checks++;
    if (data_write !== 32'h0) begin
      errors++; $display("FAIL reset_wdata: got %0h want 0", data_write);
    end
    checks++;
    if (act !== 52'h0) begin
      errors++; $display("FAIL reset_stats: got %0h want 0", act);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int n, w0;
    bit to;
    set_thr(10, 20, 50, 255, 50, 255);
    clear_planes();
    hsv_mem[0] = {8'd15, 8'h00, 8'd100, 8'd100};
    start_frame();
    wait_done(n, to);
    checks++;
    if (to || n !== FRAME) begin
      errors++; $display("FAIL basic_cycles: got %0d want %0d", n, FRAME);
    end
    checks++;
    if (mask_mem[0] !== 32'hFFFFFFFF || mask_errs() !== 0) begin
      errors++; $display("FAIL basic_mask: got %0h/%0d want ffffffff/0",
                         mask_mem[0], mask_errs());
    end
    checks++;
    if (match_count !== 17'd1 || act !== exp_stats(NPIX)) begin
      errors++; $display("FAIL basic_stats: got %0h want %0h", act, exp_stats(NPIX));
    end
    w0 = nwr;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || nwr !== w0) begin
      errors++; $display("FAIL done_hold: got %b/%0d want 1/0", done, nwr - w0);
    end
  endtask

  task automatic test_wrap();
    int n;
    bit to;
    set_thr(180, 5, 50, 255, 50, 255);
    clear_planes();
    hsv_mem[0] = {8'd190, 8'h00, 8'd100, 8'd100};
    hsv_mem[1] = {8'd2, 8'h00, 8'd100, 8'd100};
    hsv_mem[2] = {8'd100, 8'h00, 8'd100, 8'd100};
    hsv_mem[3] = {8'hC0, 8'h00, 8'd100, 8'd100};
    start_frame();
    wait_done(n, to);
    checks++;
    if (to || {mask_mem[0], mask_mem[1], mask_mem[2], mask_mem[3]} !==
        {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0}) begin
      errors++; $display("FAIL wrap_mask: got %0h %0h %0h %0h want ffffffff ffffffff 0 0",
                         mask_mem[0], mask_mem[1], mask_mem[2], mask_mem[3]);
    end
    checks++;
    if (match_count !== 17'd2 || mask_errs() !== 0) begin
      errors++; $display("FAIL wrap_count: got %0d want 2", match_count);
    end
    set_thr(0, 255, 0, 255, 0, 255);
    clear_planes();
    hsv_mem[0] = {8'hC0, 8'h00, 8'd100, 8'd100};
    start_frame();
    wait_done(n, to);
    checks++;
    if (to || mask_mem[0] !== 32'h0 || match_count !== 17'(NPIX - 1)) begin
      errors++; $display("FAIL nohue: got %0h/%0d want 0/%0d",
                         mask_mem[0], match_count, NPIX - 1);
    end
  endtask

  task automatic test_bbox();
    int n;
    bit to;
    set_thr(10, 20, 50, 255, 50, 255);
    clear_planes();
    hsv_mem[3 * W + 5]   = {8'd15, 8'h00, 8'd100, 8'd100};
    hsv_mem[10 * W + 35] = {8'd12, 8'h77, 8'd60, 8'd200};
    start_frame();
    wait_done(n, to);
    checks++;
`ifdef HSV_THRESHOLD_BBOX_EN
    if (to || act !== {17'd2, 1'b1, 9'd5, 9'd35, 8'd3, 8'd10}) begin
`else
    if (to || act !== {17'd2, 35'd0}) begin
`endif
      errors++; $display("FAIL bbox: got %0h want %0h", act, exp_stats(NPIX));
    end
    checks++;
    if (mask_errs() !== 0) begin
      errors++; $display("FAIL bbox_mask: got %0d bad words want 0", mask_errs());
    end
  endtask

  task automatic test_random();
    int n, lo, hi;
    bit to;
    for (int f = 0; f < 4; f++) begin
      lo = $urandom_range(0, 140);
      hi = $urandom_range(90, 255);
      set_thr($urandom_range(0, 255), $urandom_range(0, 255),
              lo, hi, $urandom_range(0, 140), $urandom_range(90, 255));
      rand_plane(f & 1);
      start_frame();
      @(posedge clk);
      #1;
      hue_min = $urandom; hue_max = $urandom;
      sat_min = $urandom; sat_max = $urandom;
      val_min = $urandom; val_max = $urandom;
      wait_done(n, to);
      checks++;
      if (to || n + 1 !== FRAME) begin
        errors++; $display("FAIL rand_cycles[%0d]: got %0d want %0d", f, n + 1, FRAME);
      end
      checks++;
      if (mask_errs() !== 0) begin
        errors++; $display("FAIL rand_mask[%0d]: got %0d bad words want 0", f, mask_errs());
      end
      checks++;
      if (act !== exp_stats(NPIX)) begin
        errors++; $display("FAIL rand_stats[%0d]: got %0h want %0h", f, act, exp_stats(NPIX));
      end
      checks++;
      if (oob_wr !== 0) begin
        errors++; $display("FAIL rand_oob[%0d]: got %0d want 0", f, oob_wr);
      end
    end
    set_thr(m_h0, m_h1, m_s0, m_s1, m_v0, m_v1);
  endtask

  task automatic test_pause();
    int n;
    bit hit;
    logic [50:0] snap;
    set_thr(30, 220, 40, 255, 40, 255);
    rand_plane(1);
    start_frame();
    n = 0;
    hit = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!hit && address == 18'(HSV_OFF + 7)) begin
        hit = 1;
        pause = 1'b1;
        snap = {address, wren, data_write};
        for (int k = 0; k < 10; k++) begin
          @(posedge clk);
          #1;
          n++;
          checks++;
          if ({address, wren, data_write} !== snap) begin
            errors++; $display("FAIL pause_hold[%0d]: got %0h want %0h",
                               k, {address, wren, data_write}, snap);
          end
        end
        pause = 1'b0;
      end
    end while (!done && n < LIMIT);
    checks++;
    if (!hit || !done || n !== FRAME + 10) begin
      errors++; $display("FAIL pause_cycles: got %0d want %0d", n, FRAME + 10);
    end
    checks++;
    if (mask_errs() !== 0 || act !== exp_stats(NPIX)) begin
      errors++; $display("FAIL pause_result: got %0h want %0h", act, exp_stats(NPIX));
    end
  endtask

  task automatic test_abort();
    int n, w0;
    bit to;
    set_thr(0, 255, 100, 200, 100, 200);
    rand_plane(1);
    start_frame();
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (address != 18'(HSV_OFF + 100) && n < LIMIT);
    enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({wren, done, address} !== 20'h0) begin
      errors++; $display("FAIL abort_out: got %0h want 0", {wren, done, address});
    end
    checks++;
    if (act !== exp_stats(100)) begin
      errors++; $display("FAIL abort_hold: got %0h want %0h", act, exp_stats(100));
    end
    w0 = nwr;
    for (int i = 0; i < NPIX; i++) mask_mem[i] = 32'h5A5A5A5A;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (nwr !== w0) begin
      errors++; $display("FAIL abort_writes: got %0d want 0", nwr - w0);
    end
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (address !== 18'(HSV_OFF)) begin
      errors++; $display("FAIL restart_addr: got %0d want %0d", address, HSV_OFF);
    end
    wait_done(n, to);
    checks++;
    if (to || n + 2 !== FRAME || mask_errs() !== 0 || act !== exp_stats(NPIX)) begin
      errors++; $display("FAIL abort_rerun: got %0d/%0h want %0d/%0h",
                         n + 2, act, FRAME, exp_stats(NPIX));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit to;
    set_thr(200, 40, 20, 230, 20, 230);
    rand_plane(0);
    start_frame();
    repeat (200) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({address, wren, data_write, done, act} !== 104'h0) begin
      errors++; $display("FAIL midreset_out: got %0h want 0",
                         {address, wren, data_write, done, act});
    end
    reset_n = 1'b1;
    for (int i = 0; i < NPIX; i++) mask_mem[i] = 32'h5A5A5A5A;
    wait_done(n, to);
    checks++;
    if (to || n !== FRAME) begin
      errors++; $display("FAIL midreset_cycles: got %0d want %0d", n, FRAME);
    end
    checks++;
    if (mask_errs() !== 0 || act !== exp_stats(NPIX)) begin
      errors++; $display("FAIL midreset_result: got %0h want %0h", act, exp_stats(NPIX));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nwr = 0;
    oob_wr = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_bbox();
    test_random();
    test_pause();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
